// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the 5-stage MIPS core.
//   - opcode and ALUOp encodings used by the main control decoder
//   - control bundle layout (ctrl_t, NBITS_CTRL bits, MSB first:
//     RegDst, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp[1:0])
//   - default datapath widths
//   - decode_opcode(): reference main-decoder mapping from opcode to controls
package mips_pkg;

    localparam int NBITS_DATA_DFLT = 32;
    localparam int NBITS_REG_DFLT  = 5;
    localparam int NBITS_CNT_DFLT  = 16;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam int NBITS_CTRL = 9;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t decode_opcode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_RTYPE;
            end
            OP_LW: begin
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.reg_write  = 1'b1;
                c.alu_op     = ALUOP_MEM;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_MEM;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALUOP_BEQ;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// id_ex_pipeline_reg_if: bundle of ID-side inputs and EX-side outputs of the
// ID/EX pipeline register.
//   slave  : the pipeline register itself (consumes i_*, drives o_*)
//   master : the surrounding core / testbench (drives i_*, consumes o_*)
interface id_ex_pipeline_reg_if #(
    parameter int NBITS_DATA = 32,
    parameter int NBITS_REG  = 5,
    parameter int NBITS_CNT  = 16
);
    logic                  i_Valid;
    logic                  i_RegDst, i_Branch, i_MemRead, i_MemToReg;
    logic                  i_MemWrite, i_ALUSrc, i_RegWrite;
    logic [1:0]            i_ALUOp;
    logic [NBITS_DATA-1:0] i_ReadData1, i_ReadData2, i_SignExt, i_PC4;
    logic [NBITS_REG-1:0]  i_Rs, i_Rt, i_Rd;
    logic [5:0]            i_Funct;
    logic                  i_Flush, i_Hold, i_ClrCount;

    logic                  o_Valid;
    logic                  o_RegDst, o_Branch, o_MemRead, o_MemToReg;
    logic                  o_MemWrite, o_ALUSrc, o_RegWrite;
    logic [1:0]            o_ALUOp;
    logic [NBITS_DATA-1:0] o_ReadData1, o_ReadData2, o_SignExt, o_PC4;
    logic [NBITS_REG-1:0]  o_Rs, o_Rt, o_Rd;
    logic [5:0]            o_Funct;
    logic                  o_StallIF;
    logic [NBITS_CNT-1:0]  o_BubbleCount;

    modport slave (
        input  i_Valid, i_RegDst, i_Branch, i_MemRead, i_MemToReg, i_MemWrite,
               i_ALUSrc, i_RegWrite, i_ALUOp, i_ReadData1, i_ReadData2,
               i_SignExt, i_PC4, i_Rs, i_Rt, i_Rd, i_Funct,
               i_Flush, i_Hold, i_ClrCount,
        output o_Valid, o_RegDst, o_Branch, o_MemRead, o_MemToReg, o_MemWrite,
               o_ALUSrc, o_RegWrite, o_ALUOp, o_ReadData1, o_ReadData2,
               o_SignExt, o_PC4, o_Rs, o_Rt, o_Rd, o_Funct,
               o_StallIF, o_BubbleCount
    );

    modport master (
        output i_Valid, i_RegDst, i_Branch, i_MemRead, i_MemToReg, i_MemWrite,
               i_ALUSrc, i_RegWrite, i_ALUOp, i_ReadData1, i_ReadData2,
               i_SignExt, i_PC4, i_Rs, i_Rt, i_Rd, i_Funct,
               i_Flush, i_Hold, i_ClrCount,
        input  o_Valid, o_RegDst, o_Branch, o_MemRead, o_MemToReg, o_MemWrite,
               o_ALUSrc, o_RegWrite, o_ALUOp, o_ReadData1, o_ReadData2,
               o_SignExt, o_PC4, o_Rs, o_Rt, o_Rd, o_Funct,
               o_StallIF, o_BubbleCount
    );

endinterface

// File: rtl/load_use_detector.sv
// load_use_detector: combinational load-use hazard check between the
// instruction in ID and the one currently held in ID/EX.
//   i_Valid, i_RegDst, i_Branch, i_MemWrite, i_Rs, i_Rt : ID instruction
//   i_ExValid, i_ExMemRead, i_ExRt                      : ID/EX contents
//   i_Flush                                             : branch flush
//   o_Hazard  : a load in EX writes a register the ID instruction reads
//   o_StallIF : freeze PC and IF/ID (suppressed by a flush)
module load_use_detector
    import mips_pkg::*;
#(
    parameter int NBITS_REG = NBITS_REG_DFLT
) (
    input  logic                 i_Valid,
    input  logic                 i_RegDst,
    input  logic                 i_Branch,
    input  logic                 i_MemWrite,
    input  logic [NBITS_REG-1:0] i_Rs,
    input  logic [NBITS_REG-1:0] i_Rt,
    input  logic                 i_ExValid,
    input  logic                 i_ExMemRead,
    input  logic [NBITS_REG-1:0] i_ExRt,
    input  logic                 i_Flush,
    output logic                 o_Hazard,
    output logic                 o_StallIF
);

    logic uses_rt;
    logic rt_nonzero;
    logic rs_match;
    logic rt_match;

    // R-type, BEQ and SW read rt; LW writes rt rather than reading it.
    assign uses_rt    = i_RegDst | i_Branch | i_MemWrite;
    // $0 is hardwired, so a load targeting it can never create a dependency.
    assign rt_nonzero = |i_ExRt;
    assign rs_match   = (i_ExRt == i_Rs);
    assign rt_match   = uses_rt & (i_ExRt == i_Rt);

    assign o_Hazard  = i_Valid & i_ExValid & i_ExMemRead & rt_nonzero
                     & (rs_match | rt_match);
    assign o_StallIF = o_Hazard & ~i_Flush;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX pipeline register of the 5-stage MIPS core.
//   i_clk, i_reset_n : clock (rising edge), async active-low reset
//   bus (slave)      : decoder controls, operands, indices, flush/hold/clear
//                      in; registered copies, o_StallIF and o_BubbleCount out
// Update priority per edge: flush > hold > load-use bubble > capture.
// Flush and bubble only zero valid and controls; data and index fields keep
// their old values, which is harmless because nothing downstream acts on them.
module id_ex_pipeline_reg
    import mips_pkg::*;
#(
    parameter int NBITS_DATA = NBITS_DATA_DFLT,
    parameter int NBITS_REG  = NBITS_REG_DFLT,
    parameter int NBITS_CNT  = NBITS_CNT_DFLT
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    id_ex_pipeline_reg_if.slave  bus
);

    localparam logic [NBITS_CNT-1:0] CNT_MAX = '1;
    localparam logic [NBITS_CNT-1:0] CNT_ONE = NBITS_CNT'(1);

    ctrl_t                 ctrl_in;
    ctrl_t                 ctrl_d,  ctrl_q;
    logic                  valid_d, valid_q;
    logic [NBITS_DATA-1:0] rd1_d,   rd1_q;
    logic [NBITS_DATA-1:0] rd2_d,   rd2_q;
    logic [NBITS_DATA-1:0] sext_d,  sext_q;
    logic [NBITS_DATA-1:0] pc4_d,   pc4_q;
    logic [NBITS_REG-1:0]  rs_d,    rs_q;
    logic [NBITS_REG-1:0]  rt_d,    rt_q;
    logic [NBITS_REG-1:0]  rd_d,    rd_q;
    logic [5:0]            funct_d, funct_q;
    logic [NBITS_CNT-1:0]  cnt_d,   cnt_q;
    logic                  hazard;
    logic                  bubble;

    assign ctrl_in = '{
        reg_dst:    bus.i_RegDst,
        branch:     bus.i_Branch,
        mem_read:   bus.i_MemRead,
        mem_to_reg: bus.i_MemToReg,
        mem_write:  bus.i_MemWrite,
        alu_src:    bus.i_ALUSrc,
        reg_write:  bus.i_RegWrite,
        alu_op:     bus.i_ALUOp
    };

    load_use_detector #(
        .NBITS_REG (NBITS_REG)
    ) u_load_use_detector (
        .i_Valid     (bus.i_Valid),
        .i_RegDst    (bus.i_RegDst),
        .i_Branch    (bus.i_Branch),
        .i_MemWrite  (bus.i_MemWrite),
        .i_Rs        (bus.i_Rs),
        .i_Rt        (bus.i_Rt),
        .i_ExValid   (valid_q),
        .i_ExMemRead (ctrl_q.mem_read),
        .i_ExRt      (rt_q),
        .i_Flush     (bus.i_Flush),
        .o_Hazard    (hazard),
        .o_StallIF   (bus.o_StallIF)
    );

    // Only an actual bubble insertion is counted; flush and hold mask it.
    assign bubble = hazard & ~bus.i_Flush & ~bus.i_Hold;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        sext_d  = sext_q;
        pc4_d   = pc4_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        funct_d = funct_q;

        if (bus.i_Flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (bus.i_Hold) begin
            valid_d = valid_q;
        end else if (hazard) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d = bus.i_Valid;
            // An invalid slot must never carry live controls into EX.
            ctrl_d  = bus.i_Valid ? ctrl_in : '0;
            rd1_d   = bus.i_ReadData1;
            rd2_d   = bus.i_ReadData2;
            sext_d  = bus.i_SignExt;
            pc4_d   = bus.i_PC4;
            rs_d    = bus.i_Rs;
            rt_d    = bus.i_Rt;
            rd_d    = bus.i_Rd;
            funct_d = bus.i_Funct;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.i_ClrCount) begin
            cnt_d = '0;
        end else if (bubble && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            sext_q  <= '0;
            pc4_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            funct_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            sext_q  <= sext_d;
            pc4_q   <= pc4_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            funct_q <= funct_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_Valid       = valid_q;
    assign bus.o_RegDst      = ctrl_q.reg_dst;
    assign bus.o_Branch      = ctrl_q.branch;
    assign bus.o_MemRead     = ctrl_q.mem_read;
    assign bus.o_MemToReg    = ctrl_q.mem_to_reg;
    assign bus.o_MemWrite    = ctrl_q.mem_write;
    assign bus.o_ALUSrc      = ctrl_q.alu_src;
    assign bus.o_RegWrite    = ctrl_q.reg_write;
    assign bus.o_ALUOp       = ctrl_q.alu_op;
    assign bus.o_ReadData1   = rd1_q;
    assign bus.o_ReadData2   = rd2_q;
    assign bus.o_SignExt     = sext_q;
    assign bus.o_PC4         = pc4_q;
    assign bus.o_Rs          = rs_q;
    assign bus.o_Rt          = rt_q;
    assign bus.o_Rd          = rd_q;
    assign bus.o_Funct       = funct_q;
    assign bus.o_BubbleCount = cnt_q;

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the main control decoder and register file in the 5-stage MIPS core.
- Latches the decoder's control bundle together with operands and register indices, and feeds the EX stage.
- Detects load-use hazards: it inserts a bubble into EX and requests a PC/IF-ID stall.
- Supports a branch flush and an external freeze, and keeps a saturating bubble counter that the debug unit reads.

Parameters:
- NBITS_DATA, 32, width of operands, sign-extended immediate and PC+4.
- NBITS_REG, 5, register index width.
- NBITS_CNT, 16, width of the bubble counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_Valid  in  1  IF/ID holds a real instruction.
- i_RegDst, i_Branch, i_MemRead, i_MemToReg, i_MemWrite, i_ALUSrc, i_RegWrite  in  1 each  decoder controls.
- i_ALUOp  in  2  decoder ALU op class.
- i_ReadData1, i_ReadData2  in  NBITS_DATA  register file outputs.
- i_SignExt  in  NBITS_DATA  sign-extended immediate.
- i_PC4  in  NBITS_DATA  PC+4 of the ID instruction.
- i_Rs, i_Rt, i_Rd  in  NBITS_REG  register indices.
- i_Funct  in  6  funct field.
- i_Flush  in  1  branch taken in MEM; kill ID/EX.
- i_Hold  in  1  external freeze (debug step or memory wait).
- i_ClrCount  in  1  synchronous clear of the bubble counter.
- o_Valid, o_RegDst, o_Branch, o_MemRead, o_MemToReg, o_MemWrite, o_ALUSrc, o_RegWrite  out  1 each  registered copies.
- o_ALUOp  out  2  registered.
- o_ReadData1, o_ReadData2, o_SignExt, o_PC4  out  NBITS_DATA  registered.
- o_Rs, o_Rt, o_Rd  out  NBITS_REG  registered.
- o_Funct  out  6  registered.
- o_StallIF  out  1  combinational; freeze PC and IF/ID.
- o_BubbleCount  out  NBITS_CNT  saturating count of load-use bubbles.

Behaviour:
- Reset (async on i_reset_n low, released synchronously by the system): every registered output is 0, including o_Valid, all controls, data and indices, and o_BubbleCount.
- o_StallIF is 0 while reset is asserted.
- uses_rt = i_RegDst | i_Branch | i_MemWrite. This covers R-type, BEQ and SW reading rt; LW writes rt and does not read it.
- hazard = i_Valid & o_Valid & o_MemRead & (o_Rt != 0) & ((o_Rt == i_Rs) | (uses_rt & (o_Rt == i_Rt))).
- o_StallIF = hazard & ~i_Flush. This output is combinational, with no added latency.
- Per-edge update, in priority order:
  1. i_Flush=1: o_Valid and all control outputs go to 0; data and index fields hold. i_Flush overrides i_Hold.
  2. i_Hold=1: all outputs hold.
  3. hazard=1: bubble. o_Valid and controls go to 0; data and index fields hold.
  4. Otherwise: capture all inputs. o_Valid=i_Valid. When i_Valid=0, controls are forced to 0 regardless of the inputs.
- Latency: one cycle from inputs to outputs.
- The stalled instruction stays in IF/ID and is re-presented in the next cycle. Because the bubble has o_MemRead=0, hazard clears and the instruction enters EX one cycle late. A load-use pair therefore costs exactly one bubble.
- Counter:
  - i_ClrCount=1 sets the counter to 0. Clear beats increment.
  - Otherwise it increments by 1 on each edge where case 3 applies (hazard & ~i_Flush & ~i_Hold).
  - It saturates at 2^NBITS_CNT-1 and does not wrap.
- Rt=0 never triggers a hazard. Consecutive LWs to the same rt with a dependent third instruction give one bubble per dependent instruction only.
- Flush during a hazard: no bubble is counted, o_StallIF=0, and the register clears.
- Hold during a hazard: o_StallIF is still asserted, the register holds, and the counter does not increment.
- Reset mid-stall: outputs clear immediately and the hazard disappears because o_Valid=0.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (LW 6'b100011, SW 6'b101011, BEQ 6'b000100, RTYPE 6'b000000);
  - ALUOp encodings (ALUOP_MEM 2'b00, ALUOP_BEQ 2'b01, ALUOP_RTYPE 2'b10);
  - the control bundle width constant (9 bits) and its field order;
  - NBITS_DATA/NBITS_REG defaults.
- One combinational sub-module, load_use_detector, computes uses_rt, hazard and o_StallIF. The pipeline register and counter stay in the top.

Test Plan:
- Reset asserted mid-operation with nonzero state -> all outputs 0 immediately, o_BubbleCount=0, o_StallIF=0.
- LW $2,0($1) followed by ADD $3,$2,$4 -> cycle 2: o_StallIF=1 and a bubble enters EX (o_Valid=0, o_RegWrite=0). Cycle 3: ADD is captured with o_Rs=2 and o_RegDst=1. o_BubbleCount=1.
- LW $2 then SW $2,4($5) (rt source) -> one bubble. LW $2 then LW $2,0($6) (rt destination, rs=6) -> no stall. LW $0 then ADD using $0 -> no stall.
- Hazard with i_Flush=1 in the same cycle -> o_StallIF=0, o_Valid=0 next, counter unchanged. Hazard with i_Hold=1 -> o_StallIF=1, outputs frozen, counter unchanged.
- i_Valid=0 while the decoder drives R-type controls -> o_Valid=0 and all controls 0 after the edge.
- Counter preloaded near saturation (NBITS_CNT=4, 15 bubbles, then 2 more) -> o_BubbleCount=15. i_ClrCount together with a bubble -> 0.
